key_scanner: RTL
================

KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 4, giving the clock cycles each select value is held (range 2..16).
REQ-002 SHALL have parameter DEBOUNCE, default 3, giving the consecutive agreeing samples needed to change a key's state (range 1..4).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port scan_en, input, 1 bit: when high, scanning advances.
REQ-006 SHALL have port mux_out, input, 1 bit: selected key line from the downstream 16:1 key multiplexer, active high.
REQ-007 SHALL have port sel, output, 4 bits: select to the multiplexer, with sel[0..3] driving s0..s3.
REQ-008 SHALL have port keys, output, 16 bits: debounced key states, bit k = key k pressed.
REQ-009 SHALL have port note, output, 4 bits: index of the lowest-numbered pressed key.
REQ-010 SHALL have port note_valid, output, 1 bit: high when any bit of keys is set.
REQ-011 SHALL have port change, output, 1 bit: one-cycle pulse when any keys bit flips.

Function
REQ-012 SHALL hold an internal settle counter cnt (0..SETTLE-1) and a registered sel; when scan_en is high, cnt increments each cycle.
REQ-013 SHALL treat the cycle with cnt==SETTLE-1 and scan_en high as the sample cycle for slot sel; mux_out is sampled at the closing edge of that cycle.
REQ-014 SHALL, at that same closing edge, set cnt to 0 and increment sel modulo 16 (15 wraps to 0).
REQ-015 SHALL, when scan_en is low, hold sel and cnt, take no sample, and leave all debounce state unchanged; scanning resumes from the held cnt.
REQ-016 SHALL keep one per-key debounce counter dc[k] (0..DEBOUNCE-1); only slot k's sample touches keys[k] and dc[k].
REQ-017 SHALL, when a sample equals keys[k], clear dc[k].
REQ-018 SHALL, when a sample differs from keys[k] and dc[k]<DEBOUNCE-1, increment dc[k].
REQ-019 SHALL, when a sample differs from keys[k] and dc[k]==DEBOUNCE-1, invert keys[k] and clear dc[k].
REQ-020 SHALL use DEBOUNCE=1 to mean a key flips on the first differing sample.
REQ-021 SHALL register change and assert it for exactly the one cycle after the edge at which keys flips; change is 0 otherwise; at most one key flips per sample.
REQ-022 SHALL register note and note_valid from the post-update key vector at the same edge as keys, so that all four outputs are mutually consistent each cycle.
REQ-023 SHALL give note = lowest set index of keys; when keys==0, note=0 and note_valid=0.
REQ-024 SHALL treat mux_out as already synchronous to clk; no extra synchronizer is required.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set sel=0, cnt=0, all dc=0, keys=16'h0000, note=0, note_valid=0, change=0.
REQ-026 SHALL, on reset assertion mid-scan or mid-debounce, discard partial debounce progress; after release, scanning restarts at slot 0 with cnt=0.

Verification (defaults; edge n = nth rising edge after rst_n release, scan_en=1 throughout unless noted)
REQ-027 Idle sweep: mux_out=0 -> sel steps 0,1,..,15,0 every 4 cycles; sel=1 after edge 4 and sel=0 again after edge 64; keys stays 0; change never asserts.
REQ-028 Press key 5 from reset and hold -> slot 5 samples at edges 24, 88, 152; after edge 152 keys=16'h0020, note=5, note_valid=1, change=1 for exactly one cycle.
REQ-029 Glitch: key 5 high only during its first two samples, low at the third -> keys stays 0, dc[5] returns to 0, no change pulse.
REQ-030 Keys 3 and 9 held -> both bits set after 3 scans (keys=16'h0208), note=3; release key 3 -> after 3 further scans keys=16'h0200, note=9, one change pulse per flip.
REQ-031 scan_en low for 10 cycles mid-slot -> sel and cnt frozen, no sample taken; on resume, the slot completes its remaining cycles.
REQ-032 rst_n pulsed low after two agreeing samples of key 7 -> all outputs return to reset values immediately; key 7 again requires 3 fresh samples.

Source files
------------

// File: rtl/key_scanner.sv
// Scans a 16-key matrix through an external 16:1 mux, debounces each key
// and reports the debounced vector, the lowest pressed key and a change pulse.
module key_scanner #(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic [15:0] keys,
  output logic [3:0]  note,
  output logic        note_valid,
  output logic        change
);

  localparam logic [3:0] CNT_MAX = 4'(SETTLE - 1);
  localparam logic [1:0] DC_MAX  = 2'(DEBOUNCE - 1);

  logic [3:0]  cnt;
  logic [1:0]  dc [16];
  logic        sample;
  logic [15:0] keys_nxt;
  logic [1:0]  dc_nxt;
  logic        flip;
  logic [3:0]  note_nxt;

  assign sample = scan_en && (cnt == CNT_MAX);

  // Only the slot being sampled can move; the other 15 keys hold.
  always_comb begin
    keys_nxt = keys;
    dc_nxt   = dc[sel];
    flip     = 1'b0;
    if (sample) begin
      if (mux_out == keys[sel]) begin
        dc_nxt = '0;
      end else if (dc[sel] == DC_MAX) begin
        keys_nxt[sel] = ~keys[sel];
        dc_nxt        = '0;
        flip          = 1'b1;
      end else begin
        dc_nxt = dc[sel] + 2'd1;
      end
    end
  end

  // Scan downward so the lowest set index wins.
  always_comb begin
    note_nxt = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (keys_nxt[i-1]) note_nxt = 4'(i - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sel        <= '0;
      keys       <= '0;
      note       <= '0;
      note_valid <= 1'b0;
      change     <= 1'b0;
      for (int unsigned k = 0; k < 16; k++) dc[k] <= '0;
    end else begin
      if (scan_en) begin
        if (sample) begin
          cnt     <= '0;
          sel     <= sel + 4'd1;
          dc[sel] <= dc_nxt;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      keys       <= keys_nxt;
      note       <= note_nxt;
      note_valid <= |keys_nxt;
      change     <= flip;
    end
  end

endmodule
